// File: rtl/vc_var_delay_line.sv
// vc_var_delay_line: DATA_WIDTH delay pipeline with a delay selectable at run
// time (0..MAX_CYCLES), per-stage valid bits, global stall (en) and a
// synchronous flush. A new delay takes effect only on an edge where no beat is
// in flight, or on a flush. Use this block to latency-match datapath branches.
//
// Optional build macro VC_VAR_DELAY_LINE_GATE_DATA_EN:
//   defined   - out_data is 0 whenever out_val is 0, including bypass. A stage
//               data register loads only when its incoming valid bit is 1.
//   undefined - out_data shows the raw stage contents. The data registers load
//               on every advancing cycle.
module vc_var_delay_line #(
   parameter  int DATA_WIDTH = 12,
   parameter  int MAX_CYCLES = 8,
   parameter  int RESET_DLY  = MAX_CYCLES,
   localparam int DLY_W      = $clog2(MAX_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  flush,
   input  logic [DLY_W-1:0]      dly_sel,
   output logic                  dly_busy,
   input  logic                  in_val,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_val,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam logic [DLY_W-1:0] MAX_DLY = DLY_W'(MAX_CYCLES);
   localparam logic [DLY_W-1:0] RST_DLY = DLY_W'(RESET_DLY);

   // Stage i of this array is pipeline stage s[i+1].
   logic [MAX_CYCLES-1:0] val_q, val_d;
   logic [DATA_WIDTH-1:0] data_q [MAX_CYCLES];
   logic [DATA_WIDTH-1:0] data_d [MAX_CYCLES];
   logic [DLY_W-1:0]      occ_q, occ_d;
   logic [DLY_W-1:0]      dly_q, dly_d;

   logic [DLY_W-1:0]      dly_clamp;
   logic                  tap_val;
   logic [DATA_WIDTH-1:0] tap_data;
   logic                  accept;
   logic                  retire;
   logic                  dly_apply;

   // Select the output tap: bypass when the delay is 0, otherwise stage s[dly_q].
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      tap_val  = in_val;
      tap_data = in_data;
      for (int i = 0; i < MAX_CYCLES; i++) begin
         if (dly_q == DLY_W'(i + 1)) begin
            tap_val  = val_q[i];
            tap_data = data_q[i];
         end
      end
   end

   // Drive the outputs and the clamped-delay compare.
   always_comb begin
      dly_clamp = (dly_sel > MAX_DLY) ? MAX_DLY : dly_sel;
      dly_busy  = (dly_clamp != dly_q);
      out_val   = tap_val;
`ifdef VC_VAR_DELAY_LINE_GATE_DATA_EN
      out_data  = tap_val ? tap_data : '0;
`else
      out_data  = tap_data;
`endif
   end

   // Compute the next state: stage shift, occupancy tracking and delay update.
   always_comb begin
      val_d  = val_q;
      data_d = data_q;
      occ_d  = occ_q;
      dly_d  = dly_q;

      // Occupancy counts only beats in s[1..dly_q], so it stays at 0 in bypass.
      accept    = en & in_val & (dly_q != '0);
      retire    = en & tap_val & (dly_q != '0);
      dly_apply = flush | ((occ_q == '0) & ~(en & in_val));

      if (en && !flush) begin
         val_d[0] = in_val;
         for (int i = 1; i < MAX_CYCLES; i++) begin
            val_d[i] = val_q[i-1];
         end
`ifdef VC_VAR_DELAY_LINE_GATE_DATA_EN
         if (in_val) begin
            data_d[0] = in_data;
         end
         for (int i = 1; i < MAX_CYCLES; i++) begin
            if (val_q[i-1]) begin
               data_d[i] = data_q[i-1];
            end
         end
`else
         data_d[0] = in_data;
         for (int i = 1; i < MAX_CYCLES; i++) begin
            data_d[i] = data_q[i-1];
         end
`endif
         if (accept && !retire) begin
            occ_d = occ_q + DLY_W'(1);
         end else if (retire && !accept) begin
            occ_d = occ_q - DLY_W'(1);
         end
      end

      if (flush) begin
         occ_d = '0;
      end

      // Nothing is live in s[1..dly_q] here. Clearing every valid bit removes
      // stale beats beyond the old tap before the tap moves.
      if (dly_apply) begin
         val_d = '0;
         dly_d = dly_clamp;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
         val_q <= '0;
         occ_q <= '0;
         dly_q <= RST_DLY;
         // NOTE: the stage data array is reset explicitly so out_data reads 0 after reset, not X.
         for (int i = 0; i < MAX_CYCLES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         val_q  <= val_d;
         occ_q  <= occ_d;
         dly_q  <= dly_d;
         data_q <= data_d;
      end
   end

endmodule

// File: tb/tb_vc_var_delay_line.sv
// Self-checking bench for vc_var_delay_line (DATA_WIDTH=12, MAX_CYCLES=8,
// RESET_DLY=3). A queue-based model tracks each in-flight beat by its stage
// position. A negedge process compares the DUT outputs with this model on
// every cycle. Directed sequences add hand-computed literal expectations.
module tb_vc_var_delay_line;

   localparam int DW    = 12;
   localparam int MAXC  = 8;
   localparam int RDLY  = 3;
   localparam int DLY_W = $clog2(MAXC + 1);

   logic             clk     = 1'b0;
   logic             reset_n = 1'b1;
   logic             en      = 1'b1;
   logic             flush   = 1'b0;
   logic [DLY_W-1:0] dly_sel = DLY_W'(RDLY);
   logic             in_val  = 1'b0;
   logic [DW-1:0]    in_data = '0;
   logic             dly_busy;
   logic             out_val;
   logic [DW-1:0]    out_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vc_var_delay_line #(
      .DATA_WIDTH (DW),
      .MAX_CYCLES (MAXC),
      .RESET_DLY  (RDLY)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .flush    (flush),
      .dly_sel  (dly_sel),
      .dly_busy (dly_busy),
      .in_val   (in_val),
      .in_data  (in_data),
      .out_val  (out_val),
      .out_data (out_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampf(input logic [DLY_W-1:0] s);
      return (int'(s) > MAXC) ? MAXC : int'(s);
   endfunction

   // Model: active delay plus a list of beats. Each beat holds its stage
   // position: 1 after acceptance, +1 per advancing edge. A beat is visible
   // at the output while its position equals the delay.
   int            dly_m = RDLY;
   int            pos_q[$];
   logic [DW-1:0] dat_q[$];
   int            pos_n[$];
   logic [DW-1:0] dat_n[$];
   bit            apply_m;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_q.delete();
         dat_q.delete();
         dly_m = RDLY;
      end else begin
         apply_m = flush || (pos_q.size() == 0 && !(en && in_val));
         if (flush) begin
            pos_q.delete();
            dat_q.delete();
         end else if (en) begin
            pos_n.delete();
            dat_n.delete();
            foreach (pos_q[k]) begin
               if (pos_q[k] + 1 <= dly_m) begin
                  pos_n.push_back(pos_q[k] + 1);
                  dat_n.push_back(dat_q[k]);
               end
            end
            if (in_val && dly_m > 0) begin
               pos_n.push_back(1);
               dat_n.push_back(in_data);
            end
            pos_q = pos_n;
            dat_q = dat_n;
         end
         if (apply_m) dly_m = clampf(dly_sel);
      end
   end

   // Compare the DUT outputs with the model on every falling edge.
   logic          ev;
   logic [DW-1:0] ed;
   always @(negedge clk) begin
      ev = 1'b0;
      ed = '0;
      if (dly_m == 0) begin
         ev = in_val;
         ed = in_data;
      end else begin
         foreach (pos_q[k]) begin
            if (pos_q[k] == dly_m) begin
               ev = 1'b1;
               ed = dat_q[k];
            end
         end
      end
      check("m_out_val", out_val, ev);
`ifdef VC_VAR_DELAY_LINE_GATE_DATA_EN
      check("m_out_data", out_data, ev ? ed : '0);
`else
      if (ev || dly_m == 0) check("m_out_data", out_data, ed);
`endif
      check("m_dly_busy", dly_busy, clampf(dly_sel) != dly_m);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state and the busy flag against RESET_DLY.
      #1 reset_n = 1'b0;
      tick();
      tick();
      check("rst_out_val", out_val, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy_eq", dly_busy, 0);
      dly_sel = 4'd5;
      #1 check("rst_busy_ne", dly_busy, 1);
      dly_sel = 4'd3;
      #1;
      reset_n = 1'b1;

      // 1: five consecutive beats at delay 3.
      for (int i = 0; i < 10; i++) begin
         in_val  = (i < 5);
         in_data = DW'(i + 1);
         #1;
         check("t1_val", out_val, (i >= 3 && i < 8));
         if (i >= 3 && i < 8) check("t1_data", out_data, i - 2);
         tick();
      end

      // 2: a stall of two cycles stretches the latency to 5 cycles with one pulse.
      for (int i = 0; i < 9; i++) begin
         en      = !(i == 1 || i == 2);
         in_val  = (i == 0);
         in_data = 12'hABC;
         #1;
         check("t2_val", out_val, i == 5);
         if (i == 5) check("t2_data", out_data, 12'hABC);
         tick();
      end
      en = 1'b1;

      // 3: change 3 -> 6 waits for two beats to drain.
      dly_sel = 4'd6;
      for (int i = 0; i < 15; i++) begin
         in_val  = (i == 0 || i == 1 || i == 7);
         in_data = (i == 0) ? 12'h011 : (i == 1) ? 12'h022 : 12'h033;
         #1;
         check("t3_busy", dly_busy, i < 6);
         check("t3_val", out_val, (i == 3 || i == 4 || i == 13));
         if (i == 3)  check("t3_data0", out_data, 12'h011);
         if (i == 4)  check("t3_data1", out_data, 12'h022);
         if (i == 13) check("t3_data2", out_data, 12'h033);
         tick();
      end

      // 4: bypass at delay 0, then a clamped request 15 -> 8.
      dly_sel = 4'd0;
      in_val  = 1'b0;
      #1 check("t4_busy_pend", dly_busy, 1);
      tick();
      in_val  = 1'b1;
      in_data = 12'h5A5;
      #1;
      check("t4_byp_val", out_val, 1);
      check("t4_byp_data", out_data, 12'h5A5);
      check("t4_busy0", dly_busy, 0);
      tick();
      in_val  = 1'b0;
      in_data = 12'h123;
      #1;
      check("t4_byp_idle", out_val, 0);
`ifdef VC_VAR_DELAY_LINE_GATE_DATA_EN
      check("t4_byp_idata", out_data, 12'h000);
`else
      check("t4_byp_idata", out_data, 12'h123);
`endif
      tick();
      dly_sel = 4'd15;
      #1 check("t4_busy15", dly_busy, 1);
      tick();
      for (int i = 4; i < 14; i++) begin
         in_val  = (i == 4);
         in_data = 12'h0F0;
         #1;
         check("t4_busy_clamp", dly_busy, 0);
         check("t4_val8", out_val, i == 12);
         if (i == 12) check("t4_data8", out_data, 12'h0F0);
         tick();
      end

      // 5: flush with en=0 and in_val=1 drops two in-flight beats and the
      // input beat. The pending delay change to 2 takes effect.
      dly_sel = 4'd2;
      for (int i = 0; i < 14; i++) begin
         in_val  = (i == 0 || i == 1 || i == 2 || i == 11);
         in_data = (i == 11) ? 12'h0C5 : 12'hEEE;
         flush   = (i == 2);
         en      = (i != 2);
         #1;
         check("t5_busy", dly_busy, i < 3);
         check("t5_val", out_val, i == 13);
         if (i == 13) check("t5_data", out_data, 12'h0C5);
         tick();
      end
      flush = 1'b0;
      en    = 1'b1;

      // 6: asynchronous reset mid-stream at delay 2.
      for (int i = 0; i < 4; i++) begin
         in_val  = 1'b1;
         in_data = DW'(12'h100 + i);
         #1;
         check("t6_val", out_val, i >= 2);
         if (i >= 2) check("t6_data", out_data, 12'h100 + i - 2);
         if (i == 3) begin
            #1 reset_n = 1'b0;
            #1;
            check("t6_rst_val", out_val, 0);
            check("t6_rst_data", out_data, 0);
            check("t6_rst_busy", dly_busy, 1);
            in_val  = 1'b0;
            dly_sel = 4'd3;
            #1 check("t6_rst_busy3", dly_busy, 0);
         end
         tick();
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_val  = (i == 1);
         in_data = 12'h3C3;
         #1;
         check("t6_post_val", out_val, i == 4);
         if (i == 4) check("t6_post_data", out_data, 12'h3C3);
         tick();
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
